// File: rtl/fir_ctrl_regs_v2_pkg.sv
// Shared definitions for the FIR control/status register slice:
// register addresses, bit positions and the run-state encoding.
package fir_ctrl_pkg;

    // Register addresses
    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_COEF_CNT = 2;
    localparam int REG_SAMP_CNT = 3;
    localparam int REG_OUT_LEN  = 4;
    localparam int REG_RUN_CNT  = 5;

    // CTRL bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // STATUS bits; the run state occupies two bits starting at ST_STATE_LSB
    localparam int ST_DONE      = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_STATE_LSB = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } run_state_t;

endpackage

// File: rtl/fir_ctrl_regs_v2_if.sv
// Register bus coming out of the CDC write path: write strobe, address,
// write data and the registered read data returned by the register file.
interface fir_ctrl_regs_v2_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    modport master (output wr_data, output addr, output wr_en, input rd_data);
    modport slave  (input wr_data, input addr, input wr_en, output rd_data);
endinterface

// File: rtl/fir_ctrl_regs_v2_fsm.sv
// Run FSM: IDLE -> ARMED on an accepted START, ARMED -> RUN when the engine
// reports busy, back to IDLE on done (completion) or on a lost busy (error).
// Accept/complete/error are same-edge events so the register file can update
// DONE, ERR, RUN_CNT and the shadows on the very edge the state changes.
module fir_run_fsm
    import fir_ctrl_pkg::*;
#(
    parameter int COEF_W   = 6,
    parameter int SAMP_W   = 14,
    parameter int MAX_COEF = 32
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              i_start_req,
    input  logic [COEF_W-1:0] i_coef_cnt,
    input  logic [SAMP_W-1:0] i_samp_cnt,
    input  logic              i_busy,
    input  logic              i_done,
    output run_state_t        o_state,
    output logic              o_start,
    output logic              o_accept,
    output logic              o_complete,
    output logic              o_err_evt
);

    run_state_t r_state;
    logic       r_start;
    logic       w_cfg_ok;
    logic       w_busy_lost;

    // Event decode from the current state and the live configuration
    always_comb begin
        w_cfg_ok    = (i_coef_cnt != '0) && (32'(i_coef_cnt) <= 32'(MAX_COEF)) &&
                      (i_samp_cnt != '0);
        o_accept    = i_start_req && (r_state == IDLE) && w_cfg_ok;
        o_complete  = i_done && (r_state != IDLE);
        w_busy_lost = (r_state == RUN) && !i_busy && !i_done;
        o_err_evt   = (i_start_req && !o_accept) || w_busy_lost;
    end

    // State register and one-cycle start pulse
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_start <= 1'b0;
        end else begin
            r_start <= o_accept;
            case (r_state)
                IDLE:    if (o_accept) r_state <= ARMED;
                ARMED:   if (i_done) r_state <= IDLE;
                         else if (i_busy) r_state <= RUN;
                RUN:     if (i_done || !i_busy) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_start = r_start;

endmodule

// File: rtl/fir_ctrl_regs_v2.sv
// FIR engine control/status register file: CTRL, STATUS, M/N configuration,
// live OUT_LEN, completed-run counter, config shadows held stable during a
// run, and the level interrupt DONE & IRQ_EN.
module fir_ctrl_regs_v2
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int COEF_W   = 6,
    parameter int SAMP_W   = 14,
    parameter int MAX_COEF = 32
) (
    input  logic              clk_b,
    input  logic              rst_n,
    fir_ctrl_regs_v2_if.slave bus,
    output logic              start_o,
    input  logic              busy_i,
    input  logic              done_i,
    output logic [COEF_W-1:0] coef_cnt_o,
    output logic [SAMP_W-1:0] samp_cnt_o,
    output logic [SAMP_W:0]   out_len_o,
    output logic              irq_o
);

    logic              r_irq_en, r_done, r_err;
    logic [COEF_W-1:0] r_coef, r_coef_sh;
    logic [SAMP_W-1:0] r_samp, r_samp_sh;
    logic [SAMP_W:0]   r_len_sh;
    logic [DATA_W-1:0] r_run_cnt, r_rd_data;

    logic              w_wr_ctrl, w_wr_status, w_wr_coef, w_wr_samp;
    logic              w_start_req, w_cfg_err;
    logic              w_accept, w_complete, w_err_evt;
    logic [SAMP_W:0]   w_live_len;
    logic [DATA_W-1:0] w_status, w_rd_mux;
    run_state_t        w_state;

    // Write decode, config-lock violation and live M+N-1
    always_comb begin
        w_wr_ctrl   = bus.wr_en && (bus.addr == ADDR_W'(REG_CTRL));
        w_wr_status = bus.wr_en && (bus.addr == ADDR_W'(REG_STATUS));
        w_wr_coef   = bus.wr_en && (bus.addr == ADDR_W'(REG_COEF_CNT));
        w_wr_samp   = bus.wr_en && (bus.addr == ADDR_W'(REG_SAMP_CNT));
        w_start_req = w_wr_ctrl && bus.wr_data[CTRL_START];
        w_cfg_err   = (w_wr_coef || w_wr_samp) && (w_state != IDLE);
        if ((r_coef == '0) && (r_samp == '0))
            w_live_len = '0;
        else
            w_live_len = (SAMP_W+1)'(r_coef) + (SAMP_W+1)'(r_samp) - (SAMP_W+1)'(1);
    end

    fir_run_fsm #(
        .COEF_W   (COEF_W),
        .SAMP_W   (SAMP_W),
        .MAX_COEF (MAX_COEF)
    ) u_fsm (
        .clk_b       (clk_b),
        .rst_n       (rst_n),
        .i_start_req (w_start_req),
        .i_coef_cnt  (r_coef),
        .i_samp_cnt  (r_samp),
        .i_busy      (busy_i),
        .i_done      (done_i),
        .o_state     (w_state),
        .o_start     (start_o),
        .o_accept    (w_accept),
        .o_complete  (w_complete),
        .o_err_evt   (w_err_evt)
    );

    // Software-writable config; M/N frozen while the FSM is not IDLE
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_coef   <= '0;
            r_samp   <= '0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= bus.wr_data[CTRL_IRQ_EN];
            if (w_wr_coef && (w_state == IDLE)) r_coef <= COEF_W'(bus.wr_data);
            if (w_wr_samp && (w_state == IDLE)) r_samp <= SAMP_W'(bus.wr_data);
        end
    end

    // Sticky DONE/ERR (hardware set beats W1C) and completed-run counter
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            if (w_complete)
                r_done <= 1'b1;
            else if (w_accept || (w_wr_status && bus.wr_data[ST_DONE]))
                r_done <= 1'b0;
            if (w_err_evt || w_cfg_err)
                r_err <= 1'b1;
            else if (w_wr_status && bus.wr_data[ST_ERR])
                r_err <= 1'b0;
            if (w_complete) r_run_cnt <= r_run_cnt + DATA_W'(1);
        end
    end

    // Engine-facing shadows, loaded only when a START is accepted
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_coef_sh <= '0;
            r_samp_sh <= '0;
            r_len_sh  <= '0;
        end else if (w_accept) begin
            r_coef_sh <= r_coef;
            r_samp_sh <= r_samp;
            r_len_sh  <= w_live_len;
        end
    end

    // Readback mux; narrow fields are zero-extended, unmapped addresses read 0
    always_comb begin
        w_status                         = '0;
        w_status[ST_DONE]                = r_done;
        w_status[ST_BUSY]                = busy_i;
        w_status[ST_ERR]                 = r_err;
        w_status[ST_STATE_LSB +: 2]      = w_state;
        w_rd_mux                         = '0;
        case (bus.addr)
            ADDR_W'(REG_CTRL):     w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
            ADDR_W'(REG_STATUS):   w_rd_mux = w_status;
            ADDR_W'(REG_COEF_CNT): w_rd_mux = DATA_W'(r_coef);
            ADDR_W'(REG_SAMP_CNT): w_rd_mux = DATA_W'(r_samp);
            ADDR_W'(REG_OUT_LEN):  w_rd_mux = DATA_W'(w_live_len);
            ADDR_W'(REG_RUN_CNT):  w_rd_mux = r_run_cnt;
            default:               w_rd_mux = '0;
        endcase
    end

    // Registered read, one cycle of latency
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= w_rd_mux;
    end

    assign bus.rd_data = r_rd_data;
    assign coef_cnt_o  = r_coef_sh;
    assign samp_cnt_o  = r_samp_sh;
    assign out_len_o   = r_len_sh;
    assign irq_o       = r_done & r_irq_en;

endmodule
